// File: rtl/wave_sequencer_if.sv
// ---------------------------------------------------------------------------
// wave_sequencer_if
//   Configuration handshake between the SPI client register file (master)
//   and the DDS wave sequencer (slave). A config word transfers on a clock
//   edge where cfg_valid and cfg_ready are both high.
//
//   Signals
//     cfg_valid   master -> slave  config word offered
//     cfg_ready   slave  -> master config can be accepted
//     cfg_wave    master -> slave  ROM bank select (0..3)
//     cfg_step    master -> slave  phase tuning word, PHASE_W bits
//     cfg_enable  master -> slave  1 = run, 0 = stop
//     cfg_gain    master -> slave  amplitude gain (only used with AMP_SCALE_EN)
// ---------------------------------------------------------------------------
interface wave_sequencer_if #(
  parameter int PHASE_W = 24
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_wave;
  logic [PHASE_W-1:0] cfg_step;
  logic               cfg_enable;
  logic [3:0]         cfg_gain;

  modport master (
    output cfg_valid, cfg_wave, cfg_step, cfg_enable, cfg_gain,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_wave, cfg_step, cfg_enable, cfg_gain,
    output cfg_ready
  );
endinterface

// File: rtl/wave_sequencer.sv
// ---------------------------------------------------------------------------
// wave_sequencer
//   DDS sequencer for a 4-bank waveform sample ROM (4 x 2^ADDR_W x DATA_W).
//   A phase accumulator advances by the tuning word every cycle; its top
//   ADDR_W bits, prefixed with the bank number, form the ROM read address.
//   The ROM answers one cycle later and the sample is registered one cycle
//   after that. New configs arriving while running are parked in a shadow
//   copy and only take effect when the accumulator wraps, so the output
//   never switches waveform mid-period.
//
//   Ports
//     clk_i           system clock
//     rst_ni          synchronous reset, active low
//     cfg             wave_sequencer_if.slave config handshake
//     mem_addr_o      registered ROM address {bank, index}
//     mem_data_i      ROM data, valid one cycle after mem_addr_o
//     sample_o        registered output sample
//     sample_valid_o  sample_o is new this cycle
//     period_start_o  sample_o came from index 0
//     busy_o          sequencer is not idle
//
//   Build option
//     AMP_SCALE_EN    when defined, the gain is stored with each config and
//                     samples are scaled by (gain+1)/16; gain 15 is unity.
// ---------------------------------------------------------------------------
module wave_sequencer #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wave_sequencer_if.slave    cfg,
  output logic [ADDR_W+1:0]  mem_addr_o,
  input  logic [DATA_W-1:0]  mem_data_i,
  output logic [DATA_W-1:0]  sample_o,
  output logic               sample_valid_o,
  output logic               period_start_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         act_wave_q, act_wave_d;
  logic [PHASE_W-1:0] act_step_q, act_step_d;
  logic [1:0]         sh_wave_q, sh_wave_d;
  logic [PHASE_W-1:0] sh_step_q, sh_step_d;
  logic               sh_en_q, sh_en_d;
  logic [ADDR_W+1:0]  mem_addr_q, mem_addr_d;

  // Tag pipe: addr_* travels with the address, data_* with the ROM data.
  logic               addr_vld_q, addr_first_q;
  logic               data_vld_q, data_first_q;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               sample_valid_q, period_start_q;

  logic               issue, issue_first;
  logic [PHASE_W:0]   sum;
  logic               carry, xfer;

`ifdef AMP_SCALE_EN
  logic [3:0]         act_gain_q, act_gain_d;
  logic [3:0]         sh_gain_q, sh_gain_d;
  logic [3:0]         issue_gain;
  logic [3:0]         addr_gain_q, data_gain_q;
  logic [DATA_W+3:0]  prod;
`else
  logic               unused_gain;
  assign unused_gain = ^cfg.cfg_gain;
`endif

  // The extra top bit of the sum is the wrap indication; a zero step can
  // never produce it.
  assign sum   = {1'b0, phase_q} + {1'b0, act_step_q};
  assign carry = sum[PHASE_W];
  assign xfer  = cfg.cfg_valid & cfg.cfg_ready;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      act_wave_q     <= '0;
      act_step_q     <= '0;
      sh_wave_q      <= '0;
      sh_step_q      <= '0;
      sh_en_q        <= 1'b0;
      mem_addr_q     <= '0;
      addr_vld_q     <= 1'b0;
      addr_first_q   <= 1'b0;
      data_vld_q     <= 1'b0;
      data_first_q   <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      period_start_q <= 1'b0;
`ifdef AMP_SCALE_EN
      act_gain_q     <= '0;
      sh_gain_q      <= '0;
      addr_gain_q    <= '0;
      data_gain_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      act_wave_q     <= act_wave_d;
      act_step_q     <= act_step_d;
      sh_wave_q      <= sh_wave_d;
      sh_step_q      <= sh_step_d;
      sh_en_q        <= sh_en_d;
      mem_addr_q     <= mem_addr_d;
      addr_vld_q     <= issue;
      addr_first_q   <= issue_first;
      data_vld_q     <= addr_vld_q;
      data_first_q   <= addr_first_q;
      sample_q       <= sample_d;
      sample_valid_q <= data_vld_q;
      period_start_q <= data_vld_q & data_first_q;
`ifdef AMP_SCALE_EN
      act_gain_q     <= act_gain_d;
      sh_gain_q      <= sh_gain_d;
      addr_gain_q    <= issue_gain;
      data_gain_q    <= addr_gain_q;
`endif
    end
  end

  // Next state, accumulator and address generation
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    act_wave_d = act_wave_q;
    act_step_d = act_step_q;
    sh_wave_d  = sh_wave_q;
    sh_step_d  = sh_step_q;
    sh_en_d    = sh_en_q;
    mem_addr_d = mem_addr_q;
    issue      = 1'b0;
`ifdef AMP_SCALE_EN
    act_gain_d = act_gain_q;
    sh_gain_d  = sh_gain_q;
    issue_gain = act_gain_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          act_wave_d = cfg.cfg_wave;
          act_step_d = cfg.cfg_step;
          phase_d    = '0;
`ifdef AMP_SCALE_EN
          act_gain_d = cfg.cfg_gain;
          issue_gain = cfg.cfg_gain;
`endif
          // Address only moves when we actually start; a stop config just
          // loads the registers and leaves the ROM address parked.
          if (cfg.cfg_enable) begin
            state_d    = RUN;
            mem_addr_d = {cfg.cfg_wave, {ADDR_W{1'b0}}};
            issue      = 1'b1;
          end
        end
      end
      RUN, PENDING: begin
        phase_d    = sum[PHASE_W-1:0];
        mem_addr_d = {act_wave_q, sum[PHASE_W-1 -: ADDR_W]};
        issue      = 1'b1;
        if (state_q == RUN) begin
          // A config accepted on a wrap cycle waits for the following wrap,
          // which falls out naturally because only PENDING applies it.
          if (xfer) begin
            sh_wave_d = cfg.cfg_wave;
            sh_step_d = cfg.cfg_step;
            sh_en_d   = cfg.cfg_enable;
`ifdef AMP_SCALE_EN
            sh_gain_d = cfg.cfg_gain;
`endif
            state_d   = PENDING;
          end
        end else if (carry || (act_step_q == '0)) begin
          // Period boundary (or a frozen accumulator): switch to the shadow.
          act_wave_d = sh_wave_q;
          act_step_d = sh_step_q;
          phase_d    = '0;
          mem_addr_d = {sh_wave_q, {ADDR_W{1'b0}}};
`ifdef AMP_SCALE_EN
          act_gain_d = sh_gain_q;
          issue_gain = sh_gain_q;
`endif
          if (sh_en_q) begin
            state_d = RUN;
          end else begin
            // Stopping: the boundary address is not tagged, so only the
            // two samples already in flight drain out.
            state_d = IDLE;
            issue   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_first = issue && (mem_addr_d[ADDR_W-1:0] == '0);

`ifdef AMP_SCALE_EN
  // The gain rides down the tag pipe so a config change scales exactly the
  // samples fetched under it.
  assign prod = (DATA_W+4)'(mem_data_i) * (DATA_W+4)'({1'b0, data_gain_q} + 5'd1);
`endif

  // Sample capture; holds its last value when nothing new arrives
  always_comb begin
    sample_d = sample_q;
    if (data_vld_q) begin
`ifdef AMP_SCALE_EN
      sample_d = DATA_W'(prod >> 4);
`else
      sample_d = mem_data_i;
`endif
    end
  end

  // Outputs
  always_comb begin
    cfg.cfg_ready  = (state_q != PENDING);
    busy_o         = (state_q != IDLE);
    mem_addr_o     = mem_addr_q;
    sample_o       = sample_q;
    sample_valid_o = sample_valid_q;
    period_start_o = period_start_q;
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wave_sequencer
//   Scoreboard bench for wave_sequencer. A tick-level DDS model decides, from
//   phase arithmetic, which ROM word each cycle should fetch and pushes the
//   expected sample into a queue; a monitor on the falling edge pops and
//   compares whenever the DUT flags sample_valid. Control outputs (busy,
//   cfg_ready, mem_addr, held sample) are compared every cycle.
// ---------------------------------------------------------------------------
module tb_wave_sequencer;

  localparam int PHASE_W = 24;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 10;
  localparam longint PHASE_MOD = longint'(1) << PHASE_W;
  localparam int IDX_SHIFT = PHASE_W - ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] smp;
    bit                first;
    int                due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W+1:0] mem_addr;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              period_start;
  logic              busy;

  logic [DATA_W-1:0] rom [0:(4<<ADDR_W)-1];

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  bit     started = 1'b0;

  // reference model state
  bit     mRunning, mPending, mInReset;
  longint mPhase, mStep, sStep;
  int     mWave, sWave, mGain, sGain, mAddr;
  bit     sEn;
  exp_t   expQ[$];
  logic [DATA_W-1:0] expLast = '0;

  wave_sequencer_if #(.PHASE_W(PHASE_W)) bus();

  wave_sequencer #(
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg           (bus),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .sample_o      (sample),
    .sample_valid_o(sample_valid),
    .period_start_o(period_start),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // synchronous sample ROM
  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] expSample(input int addr, input int gain);
`ifdef AMP_SCALE_EN
    int p;
    p = int'(rom[addr]) * (gain + 1);
    return DATA_W'(p >> 4);
`else
    if (gain < 0) return '0;
    return rom[addr];
`endif
  endfunction

  function automatic void issue(input int wave, input int idx);
    exp_t e;
    mAddr   = wave * (1 << ADDR_W) + idx;
    e.smp   = expSample(mAddr, mGain);
    e.first = (idx == 0);
    e.due   = cyc + 2;
    expQ.push_back(e);
  endfunction

  // Behavioural DDS model, advanced once per rising edge
  always @(posedge clk) begin
    bit xfer;
    longint nxt;
    cyc++;
    started  = 1'b1;
    mInReset = !rst_n;
    if (!rst_n) begin
      mRunning = 0; mPending = 0;
      mPhase = 0; mStep = 0; sStep = 0;
      mWave = 0; sWave = 0; mGain = 0; sGain = 0; sEn = 0;
      mAddr = 0;
    end else begin
      xfer = bus.cfg_valid && !mPending;
      if (!mRunning) begin
        if (xfer) begin
          mWave = bus.cfg_wave; mStep = bus.cfg_step; mGain = bus.cfg_gain;
          mPhase = 0;
          if (bus.cfg_enable) begin
            mRunning = 1;
            issue(mWave, 0);
          end
        end
      end else begin
        nxt = mPhase + mStep;
        if (mPending && (nxt >= PHASE_MOD || mStep == 0)) begin
          mWave = sWave; mStep = sStep; mGain = sGain;
          mPhase = 0; mPending = 0;
          if (sEn) issue(mWave, 0);
          else begin
            mRunning = 0;
            mAddr = mWave * (1 << ADDR_W);
          end
        end else begin
          mPhase = nxt % PHASE_MOD;
          issue(mWave, int'(mPhase >> IDX_SHIFT));
          if (xfer) begin
            sWave = bus.cfg_wave; sStep = bus.cfg_step; sGain = bus.cfg_gain;
            sEn = bus.cfg_enable;
            mPending = 1;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (mInReset) begin
        expQ.delete();
        expLast = '0;
      end
      checkOutput("busy", busy, mRunning);
      checkOutput("cfg_ready", bus.cfg_ready, !mPending);
      checkOutput("mem_addr", mem_addr, mAddr);
      if (sample_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("sample_valid", sample_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sample_latency", cyc, e.due);
          checkOutput("sample", sample, e.smp);
          checkOutput("period_start", period_start, e.first);
          expLast = e.smp;
        end
      end else begin
        if (expQ.size() != 0 && expQ[0].due <= cyc) begin
          checkOutput("sample_valid", sample_valid, 1);
          void'(expQ.pop_front());
        end
        checkOutput("sample_hold", sample, expLast);
        checkOutput("period_start_idle", period_start, 0);
      end
    end
  end

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int wave, input int step, input bit en, input int gain);
    bit accepted;
    accepted = 0;
    @(negedge clk);
    bus.cfg_valid  = 1'b1;
    bus.cfg_wave   = 2'(wave);
    bus.cfg_step   = PHASE_W'(step);
    bus.cfg_enable = en;
    bus.cfg_gain   = 4'(gain);
    for (int i = 0; i < 4000; i++) begin
      if (bus.cfg_ready === 1'b1) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) @(negedge clk);
    bus.cfg_valid = 1'b0;
    checkOutput("cfg_accept", accepted, 1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 4000; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < (4 << ADDR_W); i++) rom[i] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    rom[0] = '1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_wave   = '0;
    bus.cfg_step   = '0;
    bus.cfg_enable = 1'b0;
    bus.cfg_gain   = '0;
    rst_n = 1'b0;
    runCycles(3);
    rst_n = 1'b1;
    checkOutput("reset_sample", sample, 0);
    checkOutput("reset_valid", sample_valid, 0);

    $display("[TB] basic sweep, bank 0 and bank 2");
    applyStimulus(0, 24'h008000, 1, 15);
    runCycles(1100);
    applyStimulus(2, 24'h008000, 1, 7);
    runCycles(1100);

    $display("[TB] mid-period switch to double step");
    applyStimulus(0, 24'h008000, 1, 15);
    runCycles(700);
    applyStimulus(1, 24'h010000, 1, 3);
    runCycles(600);

    $display("[TB] stop at wrap, then idle configs");
    applyStimulus(1, 24'h010000, 0, 15);
    waitIdle();
    runCycles(10);
    applyStimulus(3, 24'h020000, 0, 15);
    runCycles(5);
    applyStimulus(3, 24'h020000, 1, 15);
    runCycles(300);

    $display("[TB] reset while a config is pending");
    applyStimulus(0, 24'h004000, 1, 15);
    runCycles(3);
    rst_n = 1'b0;
    runCycles(1);
    rst_n = 1'b1;
    runCycles(20);

    $display("[TB] zero step, then switch");
    applyStimulus(1, 24'h008000, 1, 15);
    runCycles(20);
    applyStimulus(1, 0, 1, 15);
    runCycles(600);
    applyStimulus(2, 24'h008000, 1, 15);
    runCycles(50);

    $display("[TB] randomized configs");
    for (int t = 0; t < 40; t++) begin
      int w, s, g;
      bit en;
      w  = $urandom_range(0, 3);
      s  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(24'h004000, 24'hFFFFFF);
      en = ($urandom_range(0, 5) != 0);
      g  = $urandom_range(0, 15);
      applyStimulus(w, s, en, g);
      runCycles($urandom_range(0, 400));
    end

    applyStimulus(0, 24'h008000, 0, 15);
    waitIdle();
    runCycles(5);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
